// File: rtl/uart_cmd_controller.sv
// Receive-side host command decoder: unloads UART bytes, updates capture config, issues arm/abort pulses.
// Optional ack handshake to the transmit side is built when CMD_ACK_EN is defined.
module uart_cmd_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_empty,
    input  logic             capture_busy,
    input  logic             ack_ready,
    output logic             rx_enable,
    output logic             uld_rx_data,
    output logic [2:0]       trigger_mask,
    output logic [7:0]       pretrig_depth,
    output logic             arm_pulse,
    output logic             abort_pulse,
    output logic             ack_valid,
    output logic [7:0]       ack_byte,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_MASK  = 8'h4D;
    localparam logic [7:0] CMD_DEPTH = 8'h50;
    localparam logic [7:0] CMD_ARM   = 8'h41;
    localparam logic [7:0] CMD_ABORT = 8'h53;
    localparam logic [7:0] ACK_OK    = 8'h4B;
    localparam logic [7:0] ACK_ERR   = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        GAP1,
        WAIT_ARG,
        GAP2,
        EXEC,
        RESP,
        ACK
    } state_t;

    state_t          state;
    logic [7:0]      cmd_reg;
    logic [7:0]      arg_reg;
    logic [TO_W-1:0] to_cnt;
    logic            cmd_err;
    logic            two_byte;
    logic            exec_err;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + ERR_W'(1);
    endfunction

    always_comb begin
        two_byte = (cmd_reg == CMD_MASK) || (cmd_reg == CMD_DEPTH);
    end

    // Busy only gates config-changing and arm commands; abort is always honoured.
    always_comb begin
        exec_err = 1'b0;
        case (cmd_reg)
            CMD_MASK:  exec_err = capture_busy || (arg_reg[7:3] != '0);
            CMD_DEPTH: exec_err = capture_busy;
            CMD_ARM:   exec_err = capture_busy;
            CMD_ABORT: exec_err = 1'b0;
            default:   exec_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rx_enable     <= 1'b0;
            uld_rx_data   <= 1'b0;
            trigger_mask  <= 3'b111;
            pretrig_depth <= '0;
            arm_pulse     <= 1'b0;
            abort_pulse   <= 1'b0;
            err_count     <= '0;
            cmd_reg       <= '0;
            arg_reg       <= '0;
            to_cnt        <= '0;
            cmd_err       <= 1'b0;
`ifdef CMD_ACK_EN
            ack_valid     <= 1'b0;
            ack_byte      <= '0;
`endif
        end else begin
            rx_enable   <= 1'b1;
            uld_rx_data <= 1'b0;
            arm_pulse   <= 1'b0;
            abort_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        cmd_reg     <= rx_data;
                        cmd_err     <= 1'b0;
                        uld_rx_data <= 1'b1;
                        state       <= GAP1;
                    end
                end
                GAP1: begin
                    to_cnt <= '0;
                    state  <= two_byte ? WAIT_ARG : EXEC;
                end
                WAIT_ARG: begin
                    // A byte arriving on the final count still wins over the timeout.
                    if (!rx_empty) begin
                        arg_reg     <= rx_data;
                        uld_rx_data <= 1'b1;
                        state       <= GAP2;
                    end else if (to_cnt == TO_LAST) begin
                        cmd_err   <= 1'b1;
                        err_count <= sat_inc(err_count);
                        state     <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                GAP2: begin
                    state <= EXEC;
                end
                EXEC: begin
                    if (exec_err) begin
                        cmd_err   <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end else begin
                        case (cmd_reg)
                            CMD_MASK:  trigger_mask  <= arg_reg[2:0];
                            CMD_DEPTH: pretrig_depth <= arg_reg;
                            CMD_ARM:   arm_pulse     <= 1'b1;
                            CMD_ABORT: abort_pulse   <= 1'b1;
                            default:   ;
                        endcase
                    end
                    state <= RESP;
                end
                RESP: begin
`ifdef CMD_ACK_EN
                    ack_byte  <= cmd_err ? ACK_ERR : ACK_OK;
                    ack_valid <= 1'b1;
                    state     <= ACK;
`else
                    state     <= IDLE;
`endif
                end
                ACK: begin
`ifdef CMD_ACK_EN
                    if (ack_ready) begin
                        ack_valid <= 1'b0;
                        state     <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CMD_ACK_EN
    logic unused_ack_sigs;
    assign unused_ack_sigs = ^{ack_ready, cmd_err};
    assign ack_valid       = 1'b0;
    assign ack_byte        = '0;
`endif

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: UART byte-queue stimulus, sequential command-level reference model,
// per-cycle output comparison plus literal checkpoints. Honours CMD_ACK_EN the same way as the design.
module tb_uart_cmd_controller;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       capture_busy;
    logic       ack_ready;
    logic       rx_enable;
    logic       uld_rx_data;
    logic [2:0] trigger_mask;
    logic [7:0] pretrig_depth;
    logic       arm_pulse;
    logic       abort_pulse;
    logic       ack_valid;
    logic [7:0] ack_byte;
    logic [7:0] err_count;

    uart_cmd_controller #(
        .TIMEOUT_CYCLES(TO),
        .ERR_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_empty(rx_empty),
        .capture_busy(capture_busy),
        .ack_ready(ack_ready),
        .rx_enable(rx_enable),
        .uld_rx_data(uld_rx_data),
        .trigger_mask(trigger_mask),
        .pretrig_depth(pretrig_depth),
        .arm_pulse(arm_pulse),
        .abort_pulse(abort_pulse),
        .ack_valid(ack_valid),
        .ack_byte(ack_byte),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         mvalid = 0;
    bit         exp_rx_en, exp_uld, exp_arm, exp_abort, exp_av;
    logic [2:0] exp_mask;
    logic [7:0] exp_depth, exp_ab, exp_err;
    bit         s_rst, s_empty, s_busy, s_ready;
    logic [7:0] s_data;

    // One clock edge as the design sees it: sample inputs, retire pulses, apply reset.
    task automatic step(output bit r);
        @(posedge clk);
        s_rst   = rst;
        s_empty = rx_empty;
        s_data  = rx_data;
        s_busy  = capture_busy;
        s_ready = ack_ready;
        exp_uld   = 0;
        exp_arm   = 0;
        exp_abort = 0;
        r = s_rst;
        if (s_rst) begin
            exp_rx_en = 0;
            exp_mask  = 3'b111;
            exp_depth = 8'h00;
            exp_err   = 8'h00;
            exp_av    = 0;
            exp_ab    = 8'h00;
        end else begin
            exp_rx_en = 1;
        end
        mvalid = 1;
    endtask

    task automatic bump_err();
        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    endtask

    initial begin : model
        bit r, got, err, two;
        logic [7:0] cmd, arg;
        exp_rx_en = 0; exp_uld = 0; exp_arm = 0; exp_abort = 0; exp_av = 0;
        exp_mask = 3'b111; exp_depth = 8'h00; exp_ab = 8'h00; exp_err = 8'h00;
        forever begin
            step(r);
            if (r || s_empty) continue;
            cmd = s_data; exp_uld = 1; err = 0; arg = 8'h00; got = 0;
            step(r);
            if (r) continue;
            two = (cmd == 8'h4D) || (cmd == 8'h50);
            if (two) begin
                for (int k = 0; k < int'(TO); k++) begin
                    step(r);
                    if (r) break;
                    if (!s_empty) begin
                        arg = s_data; exp_uld = 1; got = 1;
                        break;
                    end
                end
                if (r) continue;
                if (!got) begin
                    err = 1;
                    bump_err();
                end else begin
                    step(r);
                    if (r) continue;
                end
            end
            if (!two || got) begin
                step(r);
                if (r) continue;
                case (cmd)
                    8'h4D: if (s_busy || arg[7:3] != 5'd0) err = 1; else exp_mask = arg[2:0];
                    8'h50: if (s_busy) err = 1; else exp_depth = arg;
                    8'h41: if (s_busy) err = 1; else exp_arm = 1;
                    8'h53: exp_abort = 1;
                    default: err = 1;
                endcase
                if (err) bump_err();
            end
            step(r);
            if (r) continue;
`ifdef CMD_ACK_EN
            exp_av = 1;
            exp_ab = err ? 8'h3F : 8'h4B;
            do step(r); while (!r && !s_ready);
            if (!r) exp_av = 0;
`endif
        end
    end

    // ---------------- per-cycle comparison ----------------
    int unsigned arm_cnt  = 0;
    logic [7:0]  last_ack = 8'h00;

    always @(negedge clk) begin
        if (mvalid) begin
            chk("rx_enable", rx_enable, exp_rx_en);
            chk("uld_rx_data", uld_rx_data, exp_uld);
            chk("trigger_mask", trigger_mask, exp_mask);
            chk("pretrig_depth", pretrig_depth, exp_depth);
            chk("arm_pulse", arm_pulse, exp_arm);
            chk("abort_pulse", abort_pulse, exp_abort);
            chk("ack_valid", ack_valid, exp_av);
            chk("ack_byte", ack_byte, exp_ab);
            chk("err_count", err_count, exp_err);
            chk("arm_abort_excl", arm_pulse & abort_pulse, 0);
            if (arm_pulse === 1'b1) arm_cnt++;
            if (ack_valid === 1'b1) last_ack = ack_byte;
        end
    end

    // ---------------- UART receiver stand-in and driver ----------------
    logic [7:0] q[$];
    bit         uld_seen  = 0;
    int         busy_mode = 0;  // 0 idle, 1 busy, 2 random
    int         ack_mode  = 1;  // 0 hold off, 1 ready, 2 random

    task automatic refresh_rx();
        rx_empty = (q.size() == 0);
        rx_data  = (q.size() != 0) ? q[0] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (uld_seen && q.size() != 0) void'(q.pop_front());
        uld_seen = (uld_rx_data === 1'b1);
        case (busy_mode)
            0: capture_busy = 1'b0;
            1: capture_busy = 1'b1;
            default: capture_busy = 1'($urandom_range(0, 1));
        endcase
        case (ack_mode)
            0: ack_ready = 1'b0;
            1: ack_ready = 1'b1;
            default: ack_ready = ($urandom_range(0, 2) != 0);
        endcase
        refresh_rx();
    endtask

    task automatic send(input logic [7:0] b);
        q.push_back(b);
        refresh_rx();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_queue_empty", q.size(), 0);
        repeat (12) tick();
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h4D;
            1: return 8'h50;
            2: return 8'h41;
            3: return 8'h53;
            4: return 8'($urandom_range(0, 7));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin : driver
        int unsigned base, sent, n;
        rst = 1'b1; capture_busy = 1'b0; ack_ready = 1'b1;
        refresh_rx();
        repeat (3) tick();
        chk("reset_mask", trigger_mask, 3'b111);
        chk("reset_rx_enable", rx_enable, 0);
        chk("reset_err", err_count, 0);
        rst = 1'b0;
        tick();
        chk("rx_enable_after_reset", rx_enable, 1);

        // mask write with a legal argument
        send(8'h4D); send(8'h05);
        drain(60);
        chk("mask_M05", trigger_mask, 3'b101);
`ifdef CMD_ACK_EN
        chk("ack_M05", last_ack, 8'h4B);
`endif

        // arm idle then arm while busy
        base = arm_cnt;
        send(8'h41);
        drain(60);
        chk("arm_once", arm_cnt - base, 1);
        busy_mode = 1;
        send(8'h41);
        drain(60);
        busy_mode = 0;
        chk("arm_busy_no_pulse", arm_cnt - base, 1);
        chk("err_busy_arm", err_count, 1);
        chk("model_err_busy_arm", exp_err, 8'd1);
`ifdef CMD_ACK_EN
        chk("ack_busy_arm", last_ack, 8'h3F);
`endif

        // missing argument -> timeout
        send(8'h4D);
        drain(60);
        repeat (30) tick();
        chk("err_timeout", err_count, 2);
        chk("mask_after_timeout", trigger_mask, 3'b101);

        // bad argument, unknown byte
        send(8'h4D); send(8'h08);
        drain(60);
        chk("err_bad_arg", err_count, 3);
        chk("mask_after_bad_arg", trigger_mask, 3'b101);
        send(8'h58);
        drain(60);
        chk("err_unknown", err_count, 4);

        // ack back-pressure while a byte waits
        ack_mode = 0;
        send(8'h53);
        repeat (10) tick();
        send(8'h53);
        repeat (50) tick();
`ifdef CMD_ACK_EN
        chk("ack_held", ack_valid, 1);
        chk("byte_still_waiting", q.size(), 1);
`endif
        ack_mode = 1;
        drain(60);

        // reset in the middle of a depth command
        send(8'h50); send(8'h33);
        drain(60);
        chk("depth_33", pretrig_depth, 8'h33);
        send(8'h50);
        repeat (6) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("depth_after_rst", pretrig_depth, 8'h00);
        chk("err_after_rst", err_count, 0);
        send(8'h50); send(8'h20);
        drain(60);
        chk("depth_20", pretrig_depth, 8'h20);
        chk("model_depth_20", exp_depth, 8'h20);

        // randomized traffic
        busy_mode = 2; ack_mode = 2;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            if (q.size() < 2 && $urandom_range(0, 3) == 0) send(pick());
        end
        busy_mode = 0; ack_mode = 1;
        drain(200);

        // saturate the error counter
        sent = 0; n = 0;
        while (sent < 270 && n < 6000) begin
            tick();
            n++;
            if (q.size() == 0) begin
                send(8'h5A);
                sent++;
            end
        end
        chk("saturation_sent", sent, 270);
        drain(60);
        chk("err_saturated", err_count, 8'hFF);
        chk("model_err_saturated", exp_err, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
